// File: rtl/fractal_sync_pkg.sv
// Shared definitions for the fractal synchronization tree.
package fractal_sync_pkg;

  localparam int unsigned SD_WIDTH = 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } br_tx_state_e;

endpackage

// File: rtl/fractal_sync_fifo.sv
// Generic synchronous FIFO with registered output, occupancy count and async active-low reset.
module fractal_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CntW = $clog2(DEPTH + 1),
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fractal_sync_br_tx.sv
// Back-routing response transmitter: buffers completion events and fans a response out to
// every port in the event mask with independent per-port handshakes.
module fractal_sync_br_tx
  import fractal_sync_pkg::*;
#(
  parameter int unsigned IDX_WIDTH  = 1,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 evt_valid_i,
  output logic                 evt_ready_o,
  input  logic [SD_WIDTH-1:0]  evt_sd_i,
  input  logic [IDX_WIDTH-1:0] evt_idx_i,
  output logic [SD_WIDTH-1:0]  rsp_valid_o,
  input  logic [SD_WIDTH-1:0]  rsp_ready_i,
  output logic [IDX_WIDTH-1:0] rsp_idx_o [SD_WIDTH],
  output logic                 busy_o
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [SD_WIDTH-1:0]  sd;
    logic [IDX_WIDTH-1:0] idx;
  } evt_t;

  evt_t            push_data, head;
  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CntW-1:0] fifo_count, cnt_nx;

  br_tx_state_e         state_q, state_d;
  logic [SD_WIDTH-1:0]  pending_q, pending_d, pend_nx;
  logic [IDX_WIDTH-1:0] idx_q, idx_d;
  logic                 busy_q, busy_d;

  assign evt_ready_o = ~fifo_full;
  assign fifo_push   = evt_valid_i & ~fifo_full;
  assign push_data   = '{sd: evt_sd_i, idx: evt_idx_i};

  fractal_sync_fifo #(
    .WIDTH ($bits(evt_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .data_i  (push_data),
    .pop_i   (fifo_pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    pend_nx   = pending_q & ~rsp_ready_i;
    // Load the next head as soon as the last owed port is served: no bubble between events.
    fifo_pop  = ~fifo_empty & (pend_nx == '0);
    pending_d = pend_nx;
    idx_d     = idx_q;
    state_d   = (pend_nx != '0) ? SEND : IDLE;
    if (fifo_pop) begin
      pending_d = head.sd;
      idx_d     = head.idx;
      state_d   = (head.sd != '0) ? SEND : IDLE;
    end
    cnt_nx = fifo_count + CntW'(fifo_push) - CntW'(fifo_pop);
    busy_d = (state_d == SEND) | (cnt_nx != '0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      pending_q <= '0;
      idx_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      idx_q     <= idx_d;
      busy_q    <= busy_d;
    end
  end

  assign rsp_valid_o = pending_q;
  assign busy_o      = busy_q;

  always_comb begin
    for (int p = 0; p < SD_WIDTH; p++) begin
      rsp_idx_o[p] = idx_q;
    end
  end

endmodule
